// File: rtl/kl10_pkg.sv
// Shared KL10 control-RAM definitions: sizes, load chunk geometry and load FSM states.
package kl10_pkg;

  localparam int CRM_DEPTH_DEF = 2048;
  localparam int CR_W_DEF      = 84;
  localparam int CHUNK_W       = 21;
  localparam int NUM_CHUNKS    = 4;
  localparam int ADR_W         = 12;

  localparam logic [2:0] LD_IDLE  = 3'd0;
  localparam logic [2:0] LD_C1    = 3'd1;
  localparam logic [2:0] LD_C2    = 3'd2;
  localparam logic [2:0] LD_C3    = 3'd3;
  localparam logic [2:0] LD_WRITE = 3'd4;

endpackage

// File: rtl/crm_ram.sv
// Control-RAM storage: one write port with odd-parity generation and one
// asynchronous read port with parity checking. Contents are never reset.
module crm_ram
  import kl10_pkg::*;
#(
  parameter int CRM_DEPTH = CRM_DEPTH_DEF,
  parameter int CR_W      = CR_W_DEF,
  parameter int AW        = (CRM_DEPTH > 1) ? $clog2(CRM_DEPTH) : 1
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [CR_W-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [CR_W-1:0] rd_data,
  output logic            rd_par_err
);

  logic [CR_W:0] mem [CRM_DEPTH];
  logic [CR_W:0] rd_word;

  // Store the word with a parity bit that makes the total number of ones odd.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {~(^wr_data), wr_data};
    end
  end

  assign rd_word    = mem[rd_addr];
  assign rd_data    = rd_word[CR_W-1:0];
  assign rd_par_err = ~(^rd_word);

endmodule

// File: rtl/crm_fetch.sv
// Microword fetch stage: CR register, sticky error flags and the four-chunk
// diagnostic load FSM in front of the crm_ram storage.
module crm_fetch
  import kl10_pkg::*;
#(
  parameter int CRM_DEPTH = CRM_DEPTH_DEF,
  parameter int CR_W      = CR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADR_W-1:0]   CRADR,
  input  logic               crEn,
  input  logic               ldValid,
  output logic               ldReady,
  input  logic [ADR_W-1:0]   ldAddr,
  input  logic [CHUNK_W-1:0] ldData,
  input  logic               parClr,
  output logic [CR_W-1:0]    CR,
  output logic               crValid,
  output logic               crParErr,
  output logic               crAdrErr,
  output logic               ldBusy
);

  localparam int AW   = (CRM_DEPTH > 1) ? $clog2(CRM_DEPTH) : 1;
  localparam int LD_W = NUM_CHUNKS * CHUNK_W;

  logic [2:0]       ld_state;
  logic [ADR_W-1:0] ld_addr_q;
  logic [LD_W-1:0]  ld_word;

  logic             fetch;
  logic             fetch_oor;
  logic             wr_oor;
  logic             wr_en;
  logic             fetch_par_err;
  logic             new_adr_err;
  logic [CR_W-1:0]  rd_data;
  logic             rd_par_err;
  logic [CR_W-1:0]  wr_data;

  assign ldBusy  = (ld_state != LD_IDLE);
  assign ldReady = (ld_state != LD_WRITE);

  // Fetch uses the registered busy flag, so a fetch on the chunk-0 edge still lands.
  assign fetch     = crEn && !ldBusy;
  assign fetch_oor = 32'(CRADR) >= CRM_DEPTH;
  assign wr_oor    = 32'(ld_addr_q) >= CRM_DEPTH;
  assign wr_en     = (ld_state == LD_WRITE) && !wr_oor;
  assign wr_data   = CR_W'(ld_word);

  assign fetch_par_err = fetch && !fetch_oor && rd_par_err;
  assign new_adr_err   = (fetch && fetch_oor) || ((ld_state == LD_WRITE) && wr_oor);

  crm_ram #(
    .CRM_DEPTH (CRM_DEPTH),
    .CR_W      (CR_W),
    .AW        (AW)
  ) u_ram (
    .clk        (clk),
    .wr_en      (wr_en),
    .wr_addr    (ld_addr_q[AW-1:0]),
    .wr_data    (wr_data),
    .rd_addr    (CRADR[AW-1:0]),
    .rd_data    (rd_data),
    .rd_par_err (rd_par_err)
  );

  // CR loads the addressed word (or zero when out of range) on each fetch and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CR      <= '0;
      crValid <= 1'b0;
    end else if (fetch) begin
      CR      <= fetch_oor ? '0 : rd_data;
      crValid <= 1'b1;
    end
  end

  // Sticky error flags: a new error on the same edge beats parClr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crParErr <= 1'b0;
      crAdrErr <= 1'b0;
    end else begin
      if (fetch_par_err) begin
        crParErr <= 1'b1;
      end else if (parClr) begin
        crParErr <= 1'b0;
      end
      if (new_adr_err) begin
        crAdrErr <= 1'b1;
      end else if (parClr) begin
        crAdrErr <= 1'b0;
      end
    end
  end

  // Load FSM: collect four chunks most-significant first, then spend one cycle writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state  <= LD_IDLE;
      ld_addr_q <= '0;
      ld_word   <= '0;
    end else begin
      case (ld_state)
        LD_IDLE: begin
          if (ldValid) begin
            ld_word[LD_W-1 -: CHUNK_W] <= ldData;
            ld_addr_q                  <= ldAddr;
            ld_state                   <= LD_C1;
          end
        end
        LD_C1: begin
          if (ldValid) begin
            ld_word[LD_W-1-CHUNK_W -: CHUNK_W] <= ldData;
            ld_state                           <= LD_C2;
          end
        end
        LD_C2: begin
          if (ldValid) begin
            ld_word[LD_W-1-2*CHUNK_W -: CHUNK_W] <= ldData;
            ld_state                             <= LD_C3;
          end
        end
        LD_C3: begin
          if (ldValid) begin
            ld_word[CHUNK_W-1:0] <= ldData;
            ld_state             <= LD_WRITE;
          end
        end
        LD_WRITE: begin
          ld_state <= LD_IDLE;
        end
        default: begin
          ld_state <= LD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crm_fetch.sv
// Self-checking bench for crm_fetch: directed vector table, hand-written
// multi-cycle corner cases and a randomized run against a behavioural model.
module tb_crm_fetch;

  localparam int DEPTH = 2048;
  localparam int W     = 84;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] CRADR = '0;
  logic        crEn = 1'b0;
  logic        ldValid = 1'b0;
  logic [11:0] ldAddr = '0;
  logic [20:0] ldData = '0;
  logic        parClr = 1'b0;
  logic        ldReady;
  logic [W-1:0] CR;
  logic        crValid;
  logic        crParErr;
  logic        crAdrErr;
  logic        ldBusy;

  crm_fetch #(.CRM_DEPTH(DEPTH), .CR_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .CRADR    (CRADR),
    .crEn     (crEn),
    .ldValid  (ldValid),
    .ldReady  (ldReady),
    .ldAddr   (ldAddr),
    .ldData   (ldData),
    .parClr   (parClr),
    .CR       (CR),
    .crValid  (crValid),
    .crParErr (crParErr),
    .crAdrErr (crAdrErr),
    .ldBusy   (ldBusy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  string cur_tag = "init";

  // Behavioural model: memory as plain arrays, load progress as a chunk count.
  logic [W-1:0] m_mem [DEPTH];
  bit           m_bad [DEPTH];
  bit           m_written [DEPTH];
  logic [W-1:0] m_cr;
  bit           m_valid, m_par, m_adr;
  int           m_count;
  bit           m_wpend;
  logic [20:0]  m_chunk [4];
  logic [11:0]  m_addr;

  localparam logic [W-1:0] W123 = {21'h1FFFFF, 21'h000000, 21'h0AAAAA, 21'h000001};
  localparam logic [W-1:0] W010 = 84'h0123456789ABCDEF01234;
  localparam logic [W-1:0] W055 = 84'hFEDCBA9876543210FEDCB;

  typedef struct {
    logic         cr_en;
    logic [11:0]  cradr;
    logic         ld_valid;
    logic [11:0]  ld_addr;
    logic [20:0]  ld_data;
    logic         par_clr;
    logic [W-1:0] exp_cr;
    logic         exp_valid;
    logic         exp_par;
    logic         exp_adr;
    logic         exp_busy;
    logic         exp_ready;
  } vec_t;

  vec_t vecs [8];

  task automatic model_reset();
    m_cr    = '0;
    m_valid = 1'b0;
    m_par   = 1'b0;
    m_adr   = 1'b0;
    m_count = 0;
    m_wpend = 1'b0;
  endtask

  task automatic model_step(input bit en, input logic [11:0] a, input bit lv,
                            input logic [11:0] la, input logic [20:0] ld, input bit pc);
    bit busy;
    bit new_adr;
    bit new_par;
    busy    = (m_count > 0) || m_wpend;
    new_adr = 1'b0;
    new_par = 1'b0;
    if (en && !busy) begin
      m_valid = 1'b1;
      if (int'(a) >= DEPTH) begin
        m_cr    = '0;
        new_adr = 1'b1;
      end else begin
        m_cr    = m_mem[a[10:0]];
        new_par = m_bad[a[10:0]];
      end
    end
    if (m_wpend) begin
      if (int'(m_addr) < DEPTH) begin
        m_mem[m_addr[10:0]]     = {m_chunk[0], m_chunk[1], m_chunk[2], m_chunk[3]};
        m_bad[m_addr[10:0]]     = 1'b0;
        m_written[m_addr[10:0]] = 1'b1;
      end else begin
        new_adr = 1'b1;
      end
      m_wpend = 1'b0;
    end else if (lv) begin
      if (m_count == 0) m_addr = la;
      m_chunk[m_count] = ld;
      m_count++;
      if (m_count == 4) begin
        m_count = 0;
        m_wpend = 1'b1;
      end
    end
    m_par = new_par ? 1'b1 : (pc ? 1'b0 : m_par);
    m_adr = new_adr ? 1'b1 : (pc ? 1'b0 : m_adr);
  endtask

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_word({tag, ".CR"},       CR,       m_cr);
    check_bit ({tag, ".crValid"},  crValid,  m_valid);
    check_bit ({tag, ".crParErr"}, crParErr, m_par);
    check_bit ({tag, ".crAdrErr"}, crAdrErr, m_adr);
    check_bit ({tag, ".ldBusy"},   ldBusy,   (m_count > 0) || m_wpend);
    check_bit ({tag, ".ldReady"},  ldReady,  !m_wpend);
  endtask

  // Drive one cycle of inputs, advance the model, then compare just after the edge.
  task automatic apply_stimulus(input bit en, input logic [11:0] a, input bit lv,
                                input logic [11:0] la, input logic [20:0] ld, input bit pc);
    crEn    = en;
    CRADR   = a;
    ldValid = lv;
    ldAddr  = la;
    ldData  = ld;
    parClr  = pc;
    model_step(en, a, lv, la, ld, pc);
    @(posedge clk);
    #1;
    check_model(cur_tag);
  endtask

  task automatic load_word(input logic [11:0] addr, input logic [W-1:0] word);
    apply_stimulus(1'b0, 12'h0, 1'b1, addr,  word[83:63], 1'b0);
    apply_stimulus(1'b0, 12'h0, 1'b1, 12'h0, word[62:42], 1'b0);
    apply_stimulus(1'b0, 12'h0, 1'b1, 12'h0, word[41:21], 1'b0);
    apply_stimulus(1'b0, 12'h0, 1'b1, 12'h0, word[20:0],  1'b0);
    apply_stimulus(1'b0, 12'h0, 1'b0, 12'h0, 21'h0,       1'b0);
  endtask

  initial begin
    logic [11:0] fetch_pool [7];
    logic [11:0] load_pool [5];
    logic [W-1:0] w200;

    fetch_pool = '{12'h123, 12'h010, 12'h055, 12'h200, 12'h7FF, 12'h800, 12'hFFF};
    load_pool  = '{12'h123, 12'h200, 12'h7FF, 12'h300, 12'hA00};

    //                cr_en cradr   lv  ld_addr  ld_data    pc  exp_cr  val par adr busy rdy
    vecs[0] = '{1'b0, 12'h000, 1'b1, 12'h123, 21'h1FFFFF, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 12'h000, 1'b1, 12'h000, 21'h000000, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 12'h000, 1'b1, 12'h000, 21'h0AAAAA, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 12'h000, 1'b1, 12'h000, 21'h000001, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 12'h000, 1'b0, 12'h000, 21'h000000, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 12'h123, 1'b0, 12'h000, 21'h000000, 1'b0, W123, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 12'h800, 1'b0, 12'h000, 21'h000000, 1'b0, '0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 12'h000, 1'b0, 12'h000, 21'h000000, 1'b1, '0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    model_reset();
    #12;
    cur_tag = "reset";
    check_model(cur_tag);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 12'h0, 1'b0, 12'h0, 21'h0, 1'b0);

    // Directed vector table: load 0x123, fetch it, out-of-range fetch, clear
    cur_tag = "table";
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].cr_en, vecs[i].cradr, vecs[i].ld_valid,
                     vecs[i].ld_addr, vecs[i].ld_data, vecs[i].par_clr);
      check_word($sformatf("vec%0d.CR", i),       CR,       vecs[i].exp_cr);
      check_bit ($sformatf("vec%0d.crValid", i),  crValid,  vecs[i].exp_valid);
      check_bit ($sformatf("vec%0d.crParErr", i), crParErr, vecs[i].exp_par);
      check_bit ($sformatf("vec%0d.crAdrErr", i), crAdrErr, vecs[i].exp_adr);
      check_bit ($sformatf("vec%0d.ldBusy", i),   ldBusy,   vecs[i].exp_busy);
      check_bit ($sformatf("vec%0d.ldReady", i),  ldReady,  vecs[i].exp_ready);
    end

    // Corrupted parity at 0x010 is sticky and beats parClr on an erroring fetch
    cur_tag = "parity";
    load_word(12'h010, W010);
    dut.u_ram.mem[16][W] = ~dut.u_ram.mem[16][W];
    m_bad[16] = 1'b1;
    apply_stimulus(1'b1, 12'h010, 1'b0, 12'h0, 21'h0, 1'b0);
    check_word("par_fetch.CR", CR, W010);
    check_bit("par_fetch.crParErr", crParErr, 1'b1);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 12'h123, 1'b0, 12'h0, 21'h0, 1'b0);
      check_bit($sformatf("par_sticky%0d", i), crParErr, 1'b1);
    end
    apply_stimulus(1'b1, 12'h010, 1'b0, 12'h0, 21'h0, 1'b1);
    check_bit("par_clr_vs_err", crParErr, 1'b1);
    apply_stimulus(1'b1, 12'h123, 1'b0, 12'h0, 21'h0, 1'b1);
    check_bit("par_clr_clean", crParErr, 1'b0);

    // Stall in C2 for three cycles while fetches are requested
    cur_tag = "c2_hold";
    apply_stimulus(1'b0, 12'h0, 1'b1, 12'h200, 21'h13579, 1'b0);
    apply_stimulus(1'b0, 12'h0, 1'b1, 12'h000, 21'h02468, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 12'h010, 1'b0, 12'h0, 21'h0, 1'b0);
      check_word($sformatf("c2_hold%0d.CR", i), CR, W123);
      check_bit($sformatf("c2_hold%0d.ldBusy", i), ldBusy, 1'b1);
      check_bit($sformatf("c2_hold%0d.crParErr", i), crParErr, 1'b0);
    end
    apply_stimulus(1'b1, 12'h010, 1'b1, 12'h0, 21'h1ABCD, 1'b0);
    apply_stimulus(1'b0, 12'h0,   1'b1, 12'h0, 21'h0F0F0, 1'b0);
    check_bit("c2_hold.write_state_ready", ldReady, 1'b0);
    apply_stimulus(1'b0, 12'h0,   1'b0, 12'h0, 21'h0, 1'b0);
    w200 = {21'h13579, 21'h02468, 21'h1ABCD, 21'h0F0F0};
    apply_stimulus(1'b1, 12'h200, 1'b0, 12'h0, 21'h0, 1'b0);
    check_word("c2_hold.fetch200", CR, w200);

    // Reset in C2 discards the partial load and leaves the target untouched
    cur_tag = "midreset";
    load_word(12'h055, W055);
    apply_stimulus(1'b0, 12'h0, 1'b1, 12'h055, 21'h11111, 1'b0);
    apply_stimulus(1'b0, 12'h0, 1'b1, 12'h000, 21'h22222, 1'b0);
    crEn = 1'b0;
    ldValid = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_model(cur_tag);
    check_bit("midreset.ldBusy", ldBusy, 1'b0);
    check_bit("midreset.crValid", crValid, 1'b0);
    check_word("midreset.CR", CR, '0);
    #2;
    rst_n = 1'b1;
    apply_stimulus(1'b0, 12'h0, 1'b0, 12'h0, 21'h0, 1'b0);
    apply_stimulus(1'b1, 12'h055, 1'b0, 12'h0, 21'h0, 1'b0);
    check_word("midreset.untouched", CR, W055);

    // Fetch on the chunk-0 edge completes; the next four fetches stall
    cur_tag = "chunk0_fetch";
    apply_stimulus(1'b1, 12'h123, 1'b1, 12'h7FF, 21'h0ABCD, 1'b0);
    check_word("chunk0_fetch.CR", CR, W123);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 12'h055, (i < 3), 12'h0, 21'(i + 5), 1'b0);
      check_word($sformatf("stall%0d.CR", i), CR, W123);
    end
    check_bit("stall.ldBusy_after_write", ldBusy, 1'b0);
    apply_stimulus(1'b1, 12'h7FF, 1'b0, 12'h0, 21'h0, 1'b0);

    // Out-of-range load target is dropped and flags an address error
    cur_tag = "oor_load";
    load_word(12'hA00, W055);
    check_bit("oor_load.crAdrErr", crAdrErr, 1'b1);
    apply_stimulus(1'b0, 12'h0, 1'b0, 12'h0, 21'h0, 1'b1);

    // Randomized traffic against the model
    cur_tag = "random";
    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      bit en;
      a  = fetch_pool[$urandom_range(6, 0)];
      en = ($urandom_range(1, 0) == 1);
      if (int'(a) < DEPTH && !m_written[a[10:0]]) en = 1'b0;
      apply_stimulus(en, a, ($urandom_range(2, 0) != 0),
                     load_pool[$urandom_range(4, 0)], 21'($urandom),
                     ($urandom_range(5, 0) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crm_fetch.md
CRM_FETCH -- requirements
Module: crm_fetch

Interface
REQ-001 Parameter CRM_DEPTH, default 2048: number of control-RAM words implemented.
REQ-002 Parameter CR_W, default 84: microword width in bits, excluding parity.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port CRADR, input, 12: next microinstruction address from the CRA stage.
REQ-006 Port crEn, input, 1: fetch advance; high loads CR from CRADR.
REQ-007 Port ldValid, input, 1: diagnostic load chunk valid.
REQ-008 Port ldReady, output, 1: diagnostic load chunk accepted when high together with ldValid.
REQ-009 Port ldAddr, input, 12: load target address, sampled with chunk 0.
REQ-010 Port ldData, input, 21: load chunk; chunk 0 = CR[83:63] ... chunk 3 = CR[20:0].
REQ-011 Port parClr, input, 1: clears the sticky error flags.
REQ-012 Port CR, output, CR_W: current microword register.
REQ-013 Port crValid, output, 1: CR holds a fetched word.
REQ-014 Port crParErr, output, 1: sticky parity error.
REQ-015 Port crAdrErr, output, 1: sticky out-of-range address error.
REQ-016 Port ldBusy, output, 1: load in progress; fetch stalled.

Function
REQ-017 Storage SHALL be CRM_DEPTH words of CR_W+1 bits, the extra bit being odd parity over the word.
REQ-018 Fetch SHALL have 1-cycle latency: with crEn=1 and ldBusy=0 at edge N, CR = mem[CRADR] after edge N and crValid=1.
REQ-019 With crEn=0 or ldBusy=1, CR and crValid SHALL hold.
REQ-020 If CRADR >= CRM_DEPTH on a fetch, CR SHALL load all-zero, crValid=1, crAdrErr set; storage is not read.
REQ-021 A fetched word whose stored parity is not odd SHALL set crParErr on the same edge CR loads; CR still loads the data.
REQ-022 crParErr and crAdrErr SHALL remain set until parClr=1 at an edge with no new error; a new error on the same edge wins.
REQ-023 Load FSM states: IDLE, C1, C2, C3, WRITE.
REQ-024 IDLE: ldReady=1; a handshake captures chunk 0 and ldAddr, then -> C1.
REQ-025 C1, C2, C3: ldReady=1; each handshake captures the next chunk, then -> C2, C3, WRITE respectively; without ldValid, the state holds.
REQ-026 WRITE: ldReady=0; writes the assembled word plus computed odd parity to mem[ldAddr] (dropped and crAdrErr set if ldAddr >= CRM_DEPTH), then -> IDLE.
REQ-027 ldBusy SHALL be 1 in C1, C2, C3 and WRITE; writes never coincide with fetches, so no read/write collision exists.
REQ-028 A fetch issued at the edge where IDLE accepts chunk 0 SHALL still complete; stall begins the following cycle.

Reset
REQ-029 rst_n low SHALL force CR=0, crValid=0, crParErr=0, crAdrErr=0, FSM=IDLE, ldBusy=0, and discard any partial load.
REQ-030 Storage contents SHALL NOT be reset; reads of never-written words give undefined data and parity.

Structure
REQ-031 CRM_DEPTH, CR_W, chunk width (21) and the FSM state enum SHALL live in the shared KL10 package.
REQ-032 The storage array with its parity generator and checker SHALL be one sub-module, crm_ram; crm_fetch holds CR, the error flags and the load FSM.

Verification
REQ-033 Load 0x123 with chunks 0x1FFFFF, 0, 0x0AAAAA, 1, then fetch CRADR=0x123 with crEn=1 -> next cycle CR = {0x1FFFFF,0,0x0AAAAA,1}, crValid=1, crParErr=0.
REQ-034 CRADR=0x800 with crEn=1 -> CR=0, crAdrErr=1; parClr -> 0 the next cycle.
REQ-035 Force the stored parity bit at 0x010 to be flipped, then fetch it -> crParErr=1 and sticky across 5 further clean fetches; parClr on an erroring fetch -> crParErr stays 1.
REQ-036 Hold ldValid low for 3 cycles in C2, with crEn=1 throughout -> ldBusy=1, CR unchanged, FSM stays in C2 until the handshake.
REQ-037 Assert rst_n=0 in C2 mid-load -> IDLE, ldBusy=0, CR=0, crValid=0; the target word is not written.
REQ-038 Issue crEn=1 on the same edge chunk 0 is accepted -> that fetch completes; fetches on the next 4 cycles stall.
